// File: rtl/scan_decoder.sv
// Registered one-hot decoder with a built-in address sequencer (direct, continuous scan, single sweep).
// Latency: one cycle from input to every output; no backpressure, enable pauses a running scan in place.
module scan_decoder #(
  parameter int ADDR_W  = 5,
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [ADDR_W-1:0]    A,
  input  logic [ADDR_W-1:0]    first,
  input  logic [ADDR_W-1:0]    last,
  input  logic [DWELL_W-1:0]   dwell,
  input  logic                 start,
  input  logic                 stop,
  output logic [2**ADDR_W-1:0] D,
  output logic [ADDR_W-1:0]    addr_out,
  output logic                 busy,
  output logic                 done,
  output logic                 wrap
);

  localparam int N = 2**ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]   first_q, first_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic                cont_q, cont_d;
  logic [N-1:0]        d_q, d_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wrap_q, wrap_d;
  logic                scan_req;

  assign scan_req = (mode == 2'b01) || (mode == 2'b10);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    cont_d  = cont_q;
    d_d     = '0;
    addr_d  = addr_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    wrap_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!scan_req) begin
          addr_d = A;
          if (enable) d_d = N'(1) << A;
        end else if (start && !stop) begin
          first_d = first;
          last_d  = last;
          dwell_d = dwell;
          cont_d  = (mode == 2'b01);
          ptr_d   = first;
          cnt_d   = dwell;
          state_d = S_RUN;
          busy_d  = 1'b1;
          addr_d  = first;
          if (enable) d_d = N'(1) << first;
        end
      end

      S_RUN: begin
        // stop outranks every step, including the final one of a sweep
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          busy_d = 1'b1;
          if (enable) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - 1'b1;
            end else if (ptr_q != last_q) begin
              ptr_d = ptr_q + 1'b1;
              cnt_d = dwell_q;
            end else if (cont_q) begin
              ptr_d  = first_q;
              cnt_d  = dwell_q;
              wrap_d = 1'b1;
            end else begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
          if (state_d == S_RUN) begin
            addr_d = ptr_d;
            if (enable) d_d = N'(1) << ptr_d;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
      d_q     <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      cont_q  <= cont_d;
      d_q     <= d_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign D        = d_q;
  assign addr_out = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: table-driven direct decode plus scan sequences, ADDR_W=5 and ADDR_W=3 instances.
module tb_scan_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, start, stop;
  logic [1:0]  mode;
  logic [4:0]  A, first, last;
  logic [7:0]  dwell;
  logic [31:0] D;
  logic [4:0]  addr_out;
  logic        busy, done, wrap;

  logic        rst3, en3, start3, stop3;
  logic [1:0]  mode3;
  logic [2:0]  A3, first3, last3;
  logic [7:0]  dwell3;
  logic [7:0]  D3;
  logic [2:0]  addr3;
  logic        busy3, done3, wrap3;

  scan_decoder #(.ADDR_W(5), .DWELL_W(8)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .A(A),
    .first(first), .last(last), .dwell(dwell), .start(start), .stop(stop),
    .D(D), .addr_out(addr_out), .busy(busy), .done(done), .wrap(wrap)
  );

  scan_decoder #(.ADDR_W(3), .DWELL_W(8)) u_dut3 (
    .clk(clk), .rst(rst3), .enable(en3), .mode(mode3), .A(A3),
    .first(first3), .last(last3), .dwell(dwell3), .start(start3), .stop(stop3),
    .D(D3), .addr_out(addr3), .busy(busy3), .done(done3), .wrap(wrap3)
  );

  typedef struct {
    logic [31:0] d;
    logic [4:0]  a;
    logic        busy;
    logic        done;
    logic        wrap;
    bit          use_a;
  } exp_t;

  typedef struct {
    logic [1:0]  m;
    logic        en;
    logic [4:0]  a;
    logic [31:0] d;
  } vec_t;

  exp_t  sb[$];
  vec_t  vt[8];
  int    cseq[4] = '{30, 31, 0, 1};
  int    c3seq[4] = '{6, 7, 0, 1};
  int    total = 0;
  int    bad = 0;
  string tag;

  function automatic exp_t mk(input int adr, input bit on, input bit b, input bit dn,
                              input bit w, input bit ua);
    exp_t e;
    e.d     = on ? (32'd1 << adr) : 32'd0;
    e.a     = 5'(adr);
    e.busy  = b;
    e.done  = dn;
    e.wrap  = w;
    e.use_a = ua;
    return e;
  endfunction

  task automatic cmp(input exp_t e, input logic [31:0] d, input logic [4:0] a,
                     input logic b, input logic dn, input logic w);
    total++;
    if (d !== e.d || b !== e.busy || dn !== e.done || w !== e.wrap || (e.use_a && a !== e.a)) begin
      bad++;
      $display("FAIL %s: got D=%h addr=%0d busy=%b done=%b wrap=%b, want D=%h addr=%0d busy=%b done=%b wrap=%b",
               tag, d, a, b, dn, w, e.d, e.a, e.busy, e.done, e.wrap);
    end
  endtask

  // push expectation with the stimulus, pop and compare once the edge has produced output
  task automatic cyc(input exp_t e);
    exp_t x;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    cmp(x, D, addr_out, busy, done, wrap);
  endtask

  task automatic cyc3(input exp_t e);
    exp_t x;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    cmp(x, {24'd0, D3}, {2'd0, addr3}, busy3, done3, wrap3);
  endtask

  initial begin
    exp_t e;

    vt[0] = '{2'd0, 1'b1, 5'd0,  32'h0000_0001};
    vt[1] = '{2'd0, 1'b1, 5'd8,  32'h0000_0100};
    vt[2] = '{2'd0, 1'b1, 5'd16, 32'h0001_0000};
    vt[3] = '{2'd0, 1'b1, 5'd24, 32'h0100_0000};
    vt[4] = '{2'd0, 1'b0, 5'd24, 32'h0000_0000};
    vt[5] = '{2'd3, 1'b1, 5'd31, 32'h8000_0000};
    vt[6] = '{2'd3, 1'b0, 5'd5,  32'h0000_0000};
    vt[7] = '{2'd0, 1'b1, 5'd5,  32'h0000_0020};

    rst = 1'b1; enable = 1'b1; mode = 2'd0; A = 5'd5;
    first = '0; last = '0; dwell = '0; start = 1'b0; stop = 1'b0;
    rst3 = 1'b1; en3 = 1'b1; mode3 = 2'd0; A3 = 3'd7;
    first3 = '0; last3 = '0; dwell3 = '0; start3 = 1'b0; stop3 = 1'b0;

    tag = "reset";
    cyc(mk(0, 0, 0, 0, 0, 1));
    cyc(mk(0, 0, 0, 0, 0, 1));
    rst = 1'b0;

    tag = "direct";
    for (int i = 0; i < 8; i++) begin
      mode   = vt[i].m;
      enable = vt[i].en;
      A      = vt[i].a;
      e = mk(0, 0, 0, 0, 0, 1);
      e.d = vt[i].d;
      e.a = vt[i].a;
      cyc(e);
    end
    enable = 1'b1;

    tag = "sweep";
    mode = 2'd2; first = 5'd3; last = 5'd5; dwell = 8'd1; start = 1'b1;
    for (int a = 3; a <= 5; a++) begin
      for (int k = 0; k < 2; k++) begin
        cyc(mk(a, 1, 1, 0, 0, 1));
        start = 1'b0;
      end
    end
    cyc(mk(0, 0, 0, 1, 0, 0));
    cyc(mk(0, 0, 0, 0, 0, 0));

    tag = "cont";
    mode = 2'd1; first = 5'd30; last = 5'd1; dwell = 8'd0; start = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 4; j++) begin
        cyc(mk(cseq[j], 1, 1, 0, (r > 0 && j == 0), 1));
        start = 1'b0;
      end
    end
    cyc(mk(30, 1, 1, 0, 1, 1));
    cyc(mk(31, 1, 1, 0, 0, 1));
    tag = "cont_stop";
    stop = 1'b1;
    cyc(mk(0, 0, 0, 0, 0, 0));
    stop = 1'b0;
    cyc(mk(0, 0, 0, 0, 0, 0));

    tag = "pause";
    mode = 2'd2; first = 5'd3; last = 5'd5; dwell = 8'd3; start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(mk(3, 1, 1, 0, 0, 1));
      start = 1'b0;
    end
    cyc(mk(4, 1, 1, 0, 0, 1));
    cyc(mk(4, 1, 1, 0, 0, 1));
    enable = 1'b0;
    for (int k = 0; k < 5; k++) cyc(mk(4, 0, 1, 0, 0, 1));
    enable = 1'b1;
    cyc(mk(4, 1, 1, 0, 0, 1));
    cyc(mk(4, 1, 1, 0, 0, 1));
    for (int k = 0; k < 4; k++) cyc(mk(5, 1, 1, 0, 0, 1));
    cyc(mk(0, 0, 0, 1, 0, 0));
    cyc(mk(0, 0, 0, 0, 0, 0));

    tag = "start_busy";
    mode = 2'd2; first = 5'd10; last = 5'd11; dwell = 8'd0; start = 1'b1;
    cyc(mk(10, 1, 1, 0, 0, 1));
    first = 5'd20; mode = 2'd1;
    cyc(mk(11, 1, 1, 0, 0, 1));
    start = 1'b0; mode = 2'd2;
    cyc(mk(0, 0, 0, 1, 0, 0));
    cyc(mk(0, 0, 0, 0, 0, 0));

    tag = "stop_start";
    start = 1'b1; stop = 1'b1;
    cyc(mk(0, 0, 0, 0, 0, 0));
    start = 1'b0; stop = 1'b0;
    cyc(mk(0, 0, 0, 0, 0, 0));

    tag = "single";
    first = 5'd7; last = 5'd7; dwell = 8'd0; start = 1'b1;
    cyc(mk(7, 1, 1, 0, 0, 1));
    start = 1'b0;
    cyc(mk(0, 0, 0, 1, 0, 0));
    cyc(mk(0, 0, 0, 0, 0, 0));

    tag = "stop_final";
    start = 1'b1;
    cyc(mk(7, 1, 1, 0, 0, 1));
    start = 1'b0; stop = 1'b1;
    cyc(mk(0, 0, 0, 0, 0, 0));
    stop = 1'b0;
    cyc(mk(0, 0, 0, 0, 0, 0));

    tag = "rst_mid";
    mode = 2'd1; first = 5'd0; last = 5'd31; dwell = 8'd2; start = 1'b1;
    cyc(mk(0, 1, 1, 0, 0, 1));
    start = 1'b0;
    cyc(mk(0, 1, 1, 0, 0, 1));
    cyc(mk(0, 1, 1, 0, 0, 1));
    cyc(mk(1, 1, 1, 0, 0, 1));
    rst = 1'b1; mode = 2'd0; A = 5'd9;
    cyc(mk(0, 0, 0, 0, 0, 1));
    rst = 1'b0;
    tag = "after_rst";
    mode = 2'd2; first = 5'd2; last = 5'd3; dwell = 8'd0; start = 1'b1;
    cyc(mk(2, 1, 1, 0, 0, 1));
    start = 1'b0;
    cyc(mk(3, 1, 1, 0, 0, 1));
    cyc(mk(0, 0, 0, 1, 0, 0));
    cyc(mk(0, 0, 0, 0, 0, 0));

    tag = "w3_rst";
    cyc3(mk(0, 0, 0, 0, 0, 1));
    rst3 = 1'b0;
    tag = "w3_direct";
    cyc3(mk(7, 1, 0, 0, 0, 1));
    tag = "w3_cont";
    mode3 = 2'd1; first3 = 3'd6; last3 = 3'd1; dwell3 = 8'd0; start3 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      cyc3(mk(c3seq[j], 1, 1, 0, 0, 1));
      start3 = 1'b0;
    end
    cyc3(mk(6, 1, 1, 0, 1, 1));
    cyc3(mk(7, 1, 1, 0, 0, 1));
    tag = "w3_rst_mid";
    rst3 = 1'b1;
    cyc3(mk(0, 0, 0, 0, 0, 1));
    rst3 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
# scan_decoder

Parametrised, registered one-hot decoder with a built-in address sequencer, the successor to the combinational 5-to-32 enable decoder. In direct mode it decodes an applied address into a one-hot output bus with one cycle of latency. In scan modes it walks a programmable address window itself, holding each line for a programmable dwell, either continuously or as a single sweep with a done pulse. It drives row and column select, strobe fan-out and channel-select lines.

## Interface
Parameters:
- ADDR_W, 5, address width; output bus width is 2**ADDR_W
- DWELL_W, 8, width of the dwell counter

Ports:
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  reset, synchronous and active-high
- enable  input  1  output enable; low forces D to zero and pauses a scan
- mode  input  2  00 direct, 01 continuous scan, 10 single sweep, 11 treated as direct
- A  input  ADDR_W  address decoded in direct mode
- first  input  ADDR_W  scan window start address, sampled at start
- last  input  ADDR_W  scan window end address, sampled at start
- dwell  input  DWELL_W  cycles per address minus one, sampled at start
- start  input  1  single-cycle request to begin a scan (modes 01 and 10)
- stop  input  1  abort a running scan
- D  output  2**ADDR_W  registered one-hot output (all-zero when inactive)
- addr_out  output  ADDR_W  address currently driven on D
- busy  output  1  high while a scan is running
- done  output  1  one-cycle pulse at the end of a single sweep
- wrap  output  1  one-cycle pulse when a continuous scan returns to first

## Operation
States:
- IDLE
  - If mode is 00 or 11: D <= enable ? (1 << A) : 0, and addr_out <= A.
  - If mode is 01 or 10: D <= 0.
  - A start while mode is 01 or 10 latches first, last, dwell and mode, sets ptr = first and cnt = dwell, and goes to RUN.
  - A start while mode is 00 or 11 is ignored.
- RUN
  - busy = 1; D = enable ? (1 << ptr) : 0; addr_out = ptr.
  - While enable = 1: cnt decrements each cycle. When cnt = 0 and ptr != last, ptr <= ptr + 1 (mod 2**ADDR_W) and cnt <= dwell.
  - When cnt = 0 and ptr == last:
    - latched mode 01: ptr <= first, cnt <= dwell, wrap pulses for 1 cycle, state stays RUN.
    - latched mode 10: go to DONE.
  - While enable = 0: ptr and cnt are frozen and D = 0. The scan resumes where it left off when enable returns high.
- DONE: D <= 0, busy <= 0, done = 1 for exactly one cycle, then IDLE.

Rules:
- Window wrap: if first > last, ptr counts up through 2**ADDR_W - 1, wraps to 0 and continues to last. If first == last, the window is a single address.
- start while busy is ignored. Changes to mode, first, last or dwell while busy take effect only at the next start.
- stop in RUN: D <= 0, busy <= 0 and state IDLE on the next edge. No done or wrap pulse is issued.
- Simultaneous events:
  - stop and start asserted in IDLE: stop wins and no scan begins.
  - stop in the same cycle as a sweep's final step: the stop wins and done is not issued.
- Reset has priority over all inputs, including in the middle of a scan.
  - Reset values: D = 0, addr_out = 0, busy = 0, done = 0, wrap = 0, state IDLE, ptr = 0, cnt = 0.
- D always has at most one bit set.

## Timing
- All outputs are registered; nothing is combinational from an input to an output.
- Direct mode: D and addr_out reflect the A and enable sampled one edge earlier (latency 1).
- Scan start: start sampled at edge N gives busy = 1, D = 1 << first and addr_out = first after edge N.
- Each address is held for dwell + 1 enabled cycles; dwell = 0 advances every cycle.
- Single sweep: the last address is held for dwell + 1 cycles, then done = 1 with D = 0 for one cycle, then IDLE.
  - With n addresses in the window, busy is high for exactly n·(dwell+1) enabled cycles.
- Continuous scan: wrap is high in the first cycle in which D = 1 << first again. There is no gap cycle between last and first.
- stop sampled at edge N gives D = 0 and busy = 0 after edge N.

## Test plan
1. Reset, then direct mode with enable = 1, A = 0, 8, 16, 24 applied on successive cycles -> D = 0x00000001, 0x00000100, 0x00010000, 0x01000000, each one cycle after its A. With enable = 0 -> D = 0.
2. Single sweep with first = 3, last = 5, dwell = 1 -> D holds bit 3, then bit 4, then bit 5 for 2 cycles each. busy is high for 6 cycles, done pulses once, D returns to 0.
3. Continuous scan with first = 30, last = 1, dwell = 0 -> addr_out follows 30, 31, 0, 1, 30, …; wrap pulses on each return to 30. Assert stop mid-window -> D = 0 and busy = 0 on the next cycle, no done pulse.
4. Pause: during a sweep with dwell = 3, drop enable for 5 cycles while on address 4 -> D = 0 during the pause. On resume, address 4 completes its remaining dwell and the total enabled time per address stays 4 cycles.
5. Corner cases:
   - start while busy, with first changed -> the running scan is unaffected.
   - stop and start together in IDLE -> no scan begins.
   - first == last with dwell = 0 -> a 1-cycle sweep followed by done.
6. Assert rst in the middle of a scan -> on the next edge all outputs are 0 and the state is IDLE. A new start after reset runs normally. Repeat with ADDR_W = 3 -> D is 8 bits wide and the scan wraps at 7.
